// File: rtl/demux_pkg.sv
// Shared definitions for the stream demultiplexer: counter width and
// saturation value, the one-entry slot state encoding, and the helper that
// gives the minimum select width for a channel count.
package demux_pkg;

    localparam int          DEMUX_CNT_W   = 16;
    localparam logic [15:0] DEMUX_CNT_MAX = 16'hFFFF;

    // Per-channel slot state; FULL means a word is presented downstream.
    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    // Smallest select width able to address n channels (at least 1 bit).
    function automatic int demux_sel_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/stream_slot.sv
// One-entry valid/ready register slot. The valid output is the slot state
// itself (FULL = 1), so the state is directly observable. 'free' says the
// slot can take a word this cycle: empty, or full and draining now.
module stream_slot
    import demux_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [DW-1:0] ld_data,
    output logic          valid,
    input  logic          ready,
    output logic [DW-1:0] data,
    output logic          free
);

    slot_state_e state;

    assign valid = (state == SLOT_FULL);
    assign free  = (state == SLOT_EMPTY) || ready;

    // Slot FSM: load fills (or replaces on drain+load), drain alone empties,
    // a stalled full slot holds its word unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SLOT_EMPTY;
            data  <= '0;
        end else if (load) begin
            state <= SLOT_FULL;
            data  <= ld_data;
        end else if ((state == SLOT_FULL) && ready) begin
            state <= SLOT_EMPTY;
        end
    end

endmodule

// File: rtl/stream_demux_n.sv
// Registered 1-to-NCH stream demultiplexer. Each word is steered by in_sel
// into a one-entry slot per channel; words for out-of-range or disabled
// channels are accepted and discarded, counted in a saturating drop_cnt.
// Optional build macro STREAM_DEMUX_STATS_EN adds ch_xfer_cnt, one
// saturating 16-bit output-transfer counter per channel.
module stream_demux_n
    import demux_pkg::*;
#(
    parameter int NCH  = 4,
    parameter int DW   = 8,
    parameter int SELW = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DW-1:0]              in_data,
    input  logic [SELW-1:0]            in_sel,
    input  logic [NCH-1:0]             ch_en,
    output logic [NCH-1:0]             out_valid,
    input  logic [NCH-1:0]             out_ready,
    output logic [NCH*DW-1:0]          out_data,
`ifdef STREAM_DEMUX_STATS_EN
    output logic [NCH*DEMUX_CNT_W-1:0] ch_xfer_cnt,
`endif
    output logic [DEMUX_CNT_W-1:0]     drop_cnt
);

    localparam int NSEL = 1 << SELW;

    // Enable and free flags padded to the full select range, so selects at
    // or above NCH read as disabled without an out-of-range index.
    logic [NSEL-1:0] en_ext;
    logic [NSEL-1:0] free_ext;
    logic [NCH-1:0]  free;
    logic [NCH-1:0]  load;
    logic            sel_ok;
    logic            accept;

    for (genvar k = 0; k < NSEL; k++) begin : g_ext
        if (k < NCH) begin : g_real
            assign en_ext[k]   = ch_en[k];
            assign free_ext[k] = free[k];
        end else begin : g_pad
            assign en_ext[k]   = 1'b0;
            assign free_ext[k] = 1'b0;
        end
    end

    assign sel_ok   = en_ext[in_sel];
    // Drops never stall; deliverable words wait for their own slot only.
    assign in_ready = !rst && (!sel_ok || free_ext[in_sel]);
    assign accept   = in_valid && in_ready;

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        assign load[k] = accept && sel_ok && (in_sel == SELW'(k));

        stream_slot #(.DW(DW)) u_slot (
            .clk     (clk),
            .rst     (rst),
            .load    (load[k]),
            .ld_data (in_data),
            .valid   (out_valid[k]),
            .ready   (out_ready[k]),
            .data    (out_data[k*DW +: DW]),
            .free    (free[k])
        );

`ifdef STREAM_DEMUX_STATS_EN
        logic [DEMUX_CNT_W-1:0] xfer_cnt;

        // Count completed output transfers on this channel, saturating.
        always_ff @(posedge clk) begin
            if (rst) begin
                xfer_cnt <= '0;
            end else if (out_valid[k] && out_ready[k] && (xfer_cnt != DEMUX_CNT_MAX)) begin
                xfer_cnt <= xfer_cnt + 1'b1;
            end
        end

        assign ch_xfer_cnt[k*DEMUX_CNT_W +: DEMUX_CNT_W] = xfer_cnt;
`endif
    end

    // Count accepted-but-discarded words, saturating at the maximum.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (accept && !sel_ok && (drop_cnt != DEMUX_CNT_MAX)) begin
            drop_cnt <= drop_cnt + 1'b1;
        end
    end

endmodule
